// File: rtl/down_timer_if.sv
// down_timer_if: control/status bundle for down_timer.
//   master: drives load, load_val, start, stop, auto_reload; observes count, tc, busy, done.
//   slave : the timer itself; the direction of every signal is the reverse of master.
// CNT_W sets the width of load_val and count and must match the attached timer.
interface down_timer_if #(
   parameter int unsigned CNT_W = 8
);
   logic             load;
   logic [CNT_W-1:0] load_val;
   logic             start;
   logic             stop;
   logic             auto_reload;
   logic [CNT_W-1:0] count;
   logic             tc;
   logic             busy;
   logic             done;

   modport master (
      output load, load_val, start, stop, auto_reload,
      input  count, tc, busy, done
   );

   modport slave (
      input  load, load_val, start, stop, auto_reload,
      output count, tc, busy, done
   );
endinterface

// File: rtl/down_timer.sv
// down_timer: loadable down-counter with terminal-count detection.
// It runs in one-shot or auto-reload mode and supports pause and resume.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : down_timer_if.slave
//     load/load_val : load count and reload register, then go idle
//     start / stop  : level-sampled run/resume/restart and pause requests
//     auto_reload   : periodic mode, sampled only at terminal count
//     count         : registered counter value
//     tc            : combinational, high when running at count 0
//     busy / done   : registered RUN / EXPIRED status
// On each edge the priority is load, then stop, then start, then counting.
module down_timer #(
   parameter int unsigned CNT_W = 8
) (
   input logic         clk,
   input logic         rst_n,
   down_timer_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StRun, StExpired} state_e;

   localparam logic [CNT_W-1:0] One = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] reload_q;
   logic             busy_q;
   logic             done_q;

   // busy_q and done_q are updated alongside state_q so that they track StRun and StExpired.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         count_q  <= '0;
         reload_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else if (bus.load) begin
         count_q  <= bus.load_val;
         reload_q <= bus.load_val;
         state_q  <= StIdle;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.start && !bus.stop) begin
                  state_q <= StRun;
                  busy_q  <= 1'b1;
               end
            end
            StRun: begin
               if (bus.stop) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else if (count_q != '0) begin
                  count_q <= count_q - One;
               end else if (bus.auto_reload) begin
                  count_q <= reload_q;
               end else begin
                  state_q <= StExpired;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            StExpired: begin
               // stop has no effect in this state, but it still masks a start in the same cycle.
               if (bus.start && !bus.stop) begin
                  count_q <= reload_q;
                  state_q <= StRun;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.count = count_q;
   assign bus.tc    = (state_q == StRun) && (count_q == '0);
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

endmodule

// File: tb/tb_down_timer.sv
module tb_down_timer;

   logic clk;
   logic rst_n;
   int   n_run;
   int   n_fail;

   down_timer_if #(.CNT_W(8)) a_if ();
   down_timer_if #(.CNT_W(4)) b_if ();

   down_timer #(.CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
   down_timer #(.CNT_W(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input int cnt, input bit tc, input bit busy,
                        input bit done);
      chk({tag, ".count"}, 32'(a_if.count), 32'(cnt));
      chk({tag, ".tc"}, 32'(a_if.tc), 32'(tc));
      chk({tag, ".busy"}, 32'(a_if.busy), 32'(busy));
      chk({tag, ".done"}, 32'(a_if.done), 32'(done));
   endtask

   initial begin
      n_run  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      a_if.load = 1'b0; a_if.load_val = '0; a_if.start = 1'b0; a_if.stop = 1'b0;
      a_if.auto_reload = 1'b0;
      b_if.load = 1'b0; b_if.load_val = '0; b_if.start = 1'b0; b_if.stop = 1'b0;
      b_if.auto_reload = 1'b0;
      #1;
      chk_a("reset", 0, 0, 0, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // One-shot from 5.
      a_if.load_val = 8'd5; a_if.load = 1'b1;
      tick();
      a_if.load = 1'b0;
      chk_a("os_load", 5, 0, 0, 0);
      a_if.start = 1'b1;
      tick();
      a_if.start = 1'b0;
      for (int i = 5; i >= 0; i--) begin
         chk_a($sformatf("os_run%0d", i), i, (i == 0), 1, 0);
         tick();
      end
      chk_a("os_expired", 0, 0, 0, 1);
      tick();
      chk_a("os_hold", 0, 0, 0, 1);
      a_if.start = 1'b1;
      tick();
      a_if.start = 1'b0;
      chk_a("os_restart", 5, 0, 1, 0);

      // Asynchronous reset at count 3 while running.
      tick();
      tick();
      chk_a("pre_rst", 3, 0, 1, 0);
      #2 rst_n = 1'b0;
      #1;
      chk_a("async_rst", 0, 0, 0, 0);
      rst_n = 1'b1;
      tick();
      chk_a("post_rst", 0, 0, 0, 0);

      // Auto-reload with period 4.
      a_if.load_val = 8'd3; a_if.load = 1'b1;
      tick();
      a_if.load = 1'b0;
      a_if.auto_reload = 1'b1; a_if.start = 1'b1;
      tick();
      a_if.start = 1'b0;
      for (int k = 0; k < 9; k++) begin
         chk_a($sformatf("ar_k%0d", k), 3 - (k % 4), ((k % 4) == 3), 1, 0);
         tick();
      end

      // Pause at count 2 for three cycles, then resume.
      chk_a("pause_at", 2, 0, 1, 0);
      a_if.stop = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_a($sformatf("pause%0d", k), 2, 0, 0, 0);
      end
      a_if.stop = 1'b0; a_if.start = 1'b1;
      tick();
      a_if.start = 1'b0;
      chk_a("resume2", 2, 0, 1, 0);
      tick();
      chk_a("resume1", 1, 0, 1, 0);
      tick();
      chk_a("resume0", 0, 1, 1, 0);
      // A stop on the tc cycle pauses at 0 with no reload.
      a_if.stop = 1'b1;
      tick();
      a_if.stop = 1'b0;
      chk_a("stop_on_tc", 0, 0, 0, 0);

      // Priority checks.
      a_if.auto_reload = 1'b0;
      a_if.load_val = 8'd6; a_if.load = 1'b1;
      tick();
      a_if.load = 1'b0; a_if.start = 1'b1;
      tick();
      a_if.start = 1'b0;
      tick();
      tick();
      chk_a("prio_run4", 4, 0, 1, 0);
      a_if.load_val = 8'd7; a_if.load = 1'b1;
      tick();
      a_if.load = 1'b0;
      chk_a("prio_load7", 7, 0, 0, 0);
      a_if.start = 1'b1; a_if.stop = 1'b1;
      tick();
      chk_a("prio_startstop", 7, 0, 0, 0);
      a_if.stop = 1'b0; a_if.load = 1'b1; a_if.load_val = 8'd2;
      tick();
      a_if.load = 1'b0; a_if.start = 1'b0;
      chk_a("prio_loadstart", 2, 0, 0, 0);

      // A load on the tc cycle wins over expiry.
      a_if.start = 1'b1;
      tick();
      a_if.start = 1'b0;
      tick();
      tick();
      chk_a("ltc_tc", 0, 1, 1, 0);
      a_if.load_val = 8'd9; a_if.load = 1'b1;
      tick();
      a_if.load = 1'b0;
      chk_a("ltc_load", 9, 0, 0, 0);

      // Start from count 0 gives tc at once; reload 0 keeps tc high.
      a_if.load_val = 8'd0; a_if.load = 1'b1;
      tick();
      a_if.load = 1'b0; a_if.start = 1'b1; a_if.auto_reload = 1'b1;
      tick();
      a_if.start = 1'b0;
      chk_a("zero_first", 0, 1, 1, 0);
      tick();
      chk_a("zero_cont", 0, 1, 1, 0);
      a_if.stop = 1'b1;
      tick();
      a_if.stop = 1'b0;
      chk_a("zero_stop", 0, 0, 0, 0);

      // 4-bit instance: 16 RUN cycles from 15 with no wrap.
      b_if.load_val = 4'd15; b_if.load = 1'b1;
      tick();
      b_if.load = 1'b0; b_if.start = 1'b1;
      tick();
      b_if.start = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         chk($sformatf("w4_count%0d", i), 32'(b_if.count), 32'(i));
         chk($sformatf("w4_tc%0d", i), 32'(b_if.tc), 32'(i == 0));
         tick();
      end
      chk("w4_nowrap", 32'(b_if.count), 32'd0);
      chk("w4_done", 32'(b_if.done), 32'd1);
      chk("w4_busy", 32'(b_if.busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/down_timer.md
# down_timer

Loadable down-counting timer with terminal-count detection, one-shot or auto-reload operation, and pause/resume control. It is the count-down counterpart of the free-running up-counter with overflow flag used elsewhere in the design. In auto-reload mode it produces a periodic tick every load_val+1 cycles. In one-shot mode it holds an expired/done status for software or FSM polling. Typical uses are timeouts, prescalers and periodic event generation.

## Interface
Parameters:
- CNT_W, default 8: counter, load-value and reload-register width; legal range 2..32.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- load  in  1  single-cycle strobe; loads load_val into count and reload register.
- load_val  in  CNT_W  start/reload value, unsigned.
- start  in  1  start, resume or restart request, level-sampled each cycle.
- stop  in  1  pause request, level-sampled each cycle.
- auto_reload  in  1  1 = periodic mode, 0 = one-shot; sampled only at terminal count.
- count  out  CNT_W  current counter value, registered.
- tc  out  1  terminal count; combinational, high exactly when state=RUN and count=0.
- busy  out  1  high when state=RUN.
- done  out  1  high when state=EXPIRED.

## Operation
States:
- IDLE: count holds.
- RUN: count decrements.
- EXPIRED: one-shot finished; count held at 0.

Per-edge priority is load > stop > start > counting.
- load, any state: count <= load_val; reload_reg <= load_val; state <= IDLE. done and busy drop next cycle.
- stop in RUN: state <= IDLE; count holds (pause). stop in IDLE/EXPIRED: no effect.
- start in IDLE: state <= RUN; count unchanged (resume from held value).
- start in EXPIRED: count <= reload_reg; state <= RUN (restart).
- start in RUN: ignored.
- RUN with count != 0: count <= count - 1.
- RUN with count == 0 (tc=1):
  - auto_reload=1: count <= reload_reg; stay RUN.
  - auto_reload=0: state <= EXPIRED; count stays 0.
- Arithmetic: unsigned, width CNT_W. The decrement never wraps, because the count==0 case is handled explicitly. Maximum load value is {CNT_W{1'b1}}.

## Timing
- Reset (asynchronous, immediate): count=0, reload_reg=0, state=IDLE, tc=0, busy=0, done=0. Reset asserted mid-run aborts without any tc pulse.
- Load latency: load sampled at edge N gives count=load_val after edge N.
- Start latency: busy rises after the edge sampling start; the first decrement occurs at the following edge.
- With count=C at start, tc is high in the (C+1)-th RUN cycle.
- In one-shot mode, done rises on the edge after tc.
- Auto-reload period is reload_reg+1 cycles; tc is a one-cycle pulse per period.
- reload_reg=0 with auto_reload=1: tc is continuously high while RUN.
- Boundary cases:
  - start with count=0 in IDLE: tc on the first RUN cycle.
  - stop on a tc cycle: tc is still asserted that cycle, state goes to IDLE, no reload, count stays 0.
  - load on a tc cycle: load wins; no reload and no EXPIRED.
  - start and stop in the same cycle: stop wins. A RUN timer pauses; an IDLE timer stays IDLE.

## Test plan
- Reset: assert rst_n=0 mid-run at count=3. Required: count=0, tc=0, busy=0, done=0 immediately, with no clock edge needed.
- One-shot: load_val=5, load, then start, auto_reload=0. Required:
  - count sequence 5,4,3,2,1,0;
  - tc high for exactly one cycle at count 0;
  - next cycle done=1, busy=0, count=0;
  - a later start restarts from 5.
- Auto-reload: load_val=3, auto_reload=1, start. Required: count cycles 3,2,1,0,3,2,1,0…, tc pulses every 4 cycles, done stays 0.
- Pause/resume: stop asserted for 3 cycles when count=2. Required:
  - count holds at 2 and busy=0 during the pause;
  - on start, count resumes 1,0 and tc fires.
- Priority: load 7 while RUN at count=4. Required: count=7 and IDLE. Then start and stop together: stays IDLE. Then load and start together: load wins.
- Width: CNT_W=4, load 15, one-shot. Required: 16 RUN cycles until tc, with no wrap to 15 after 0.
